// File: rtl/neuron_learn_seq.sv
// neuron_learn_seq: sequential neuron with one MAC per cycle, clip activation,
// optional delta-rule weight update and back-propagated upstream targets.
// Weights are seeded from a Galois LFSR after reset and can be host-written in IDLE.
// Optional feature: define NEURON_LEARN_BIAS_EN to add a learnable bias register
// (written via wr_idx == N, exposed on bias_o, updated in an extra UPD cycle).
module neuron_learn_seq #(
  parameter int          N        = 4,
  parameter int          IN_W     = 8,
  parameter int          W_W      = 16,
  parameter int          FRAC     = 12,
  parameter int          LR_SHIFT = 2,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          learn_i,
  input  logic [N*IN_W-1:0]             in_i,
  input  logic [IN_W-1:0]               expected_out_i,
  input  logic signed [W_W-1:0]         act_min_i,
  input  logic signed [W_W-1:0]         act_max_i,
  input  logic                          wr_en_i,
  input  logic [$clog2(N+1)-1:0]        wr_idx_i,
  input  logic signed [W_W-1:0]         wr_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [IN_W-1:0]               out_o,
  output logic [N*IN_W-1:0]             expected_in_o,
  output logic [N*W_W-1:0]              weights_o,
  output logic                          busy_o
`ifdef NEURON_LEARN_BIAS_EN
  ,
  output logic signed [W_W-1:0]         bias_o
`endif
);

  localparam int IDX_W = $clog2(N+1);
  localparam int ACC_W = IN_W + W_W + $clog2(N) + 1;
  // Common working width for activation and update arithmetic; wide enough
  // that no intermediate sum or product can wrap before saturation.
  localparam int XW    = IN_W + W_W + $clog2(N) + 4;

  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);
  localparam logic [IDX_W-1:0] FWD_LAST = IDX_W'(N-1);
`ifdef NEURON_LEARN_BIAS_EN
  localparam logic [IDX_W-1:0] UPD_LAST = IDX_W'(N);
`else
  localparam logic [IDX_W-1:0] UPD_LAST = IDX_W'(N-1);
`endif

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_FWD  = 3'd2;
  localparam logic [2:0] S_ACT  = 3'd3;
  localparam logic [2:0] S_UPD  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Unsigned saturation to IN_W bits.
  function automatic logic [IN_W-1:0] sat_u(input logic signed [XW-1:0] v);
    if (v[XW-1])              return '0;
    else if (|v[XW-2:IN_W])   return '1;
    else                      return v[IN_W-1:0];
  endfunction

  // Signed saturation to W_W bits.
  function automatic logic signed [W_W-1:0] sat_s(input logic signed [XW-1:0] v);
    if (!v[XW-1] && (|v[XW-2:W_W-1]))      return {1'b0, {(W_W-1){1'b1}}};
    else if (v[XW-1] && !(&v[XW-2:W_W-1])) return {1'b1, {(W_W-1){1'b0}}};
    else                                   return v[W_W-1:0];
  endfunction

  // Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  logic [2:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [N*W_W-1:0]        w_q, w_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [N*IN_W-1:0]       in_q, in_d;
  logic [N*IN_W-1:0]       ein_q, ein_d;
  logic [IN_W-1:0]         eo_q, eo_d;
  logic [IN_W-1:0]         out_q, out_d;
  logic                    learn_q, learn_d;
  logic signed [W_W-1:0]   amin_q, amin_d, amax_q, amax_d;
  logic                    ov_q, ov_d;
`ifdef NEURON_LEARN_BIAS_EN
  logic signed [W_W-1:0]   bias_q, bias_d;
`endif

  logic [IDX_W-1:0]        ui;
  logic signed [XW-1:0]    in_x, w_x, err_x, a_x, min_x, max_x, c_x;
  logic signed [ACC_W-1:0] mac_n;
  logic [IN_W-1:0]         out_n, ein_n;
  logic signed [W_W-1:0]   w_n;
`ifdef NEURON_LEARN_BIAS_EN
  logic signed [W_W-1:0]   bias_n;
`endif

  // Datapath: MAC term, clipped activation and per-element update values.
  always_comb begin
    ui    = (idx_q < N_IDX) ? idx_q : '0;
    in_x  = $signed(XW'(in_q[ui*IN_W +: IN_W]));
    w_x   = XW'($signed(w_q[ui*W_W +: W_W]));
    err_x = $signed(XW'(eo_q)) - $signed(XW'(out_q));
    mac_n = acc_q + ACC_W'(in_x * w_x);
    a_x   = XW'(acc_q) >>> IN_W;
`ifdef NEURON_LEARN_BIAS_EN
    a_x   = a_x + XW'(bias_q);
`endif
    min_x = XW'(amin_q);
    max_x = XW'(amax_q);
    if (max_x < min_x)     c_x = min_x;
    else if (a_x < min_x)  c_x = min_x;
    else if (a_x > max_x)  c_x = max_x;
    else                   c_x = a_x;
    out_n = sat_u((c_x - min_x) >>> (FRAC-IN_W));
    ein_n = sat_u(in_x + ((err_x * w_x) >>> (FRAC+LR_SHIFT)));
    w_n   = sat_s(w_x + ((err_x * in_x) >>> (2*IN_W-FRAC+LR_SHIFT)));
`ifdef NEURON_LEARN_BIAS_EN
    bias_n = sat_s(XW'(bias_q) + ((err_x <<< (FRAC-IN_W)) >>> LR_SHIFT));
`endif
  end

  // Sequencer: next-state for FSM, weights, accumulator and result registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    w_d     = w_q;
    acc_d   = acc_q;
    in_d    = in_q;
    ein_d   = ein_q;
    eo_d    = eo_q;
    out_d   = out_q;
    learn_d = learn_q;
    amin_d  = amin_q;
    amax_d  = amax_q;
    ov_d    = ov_q;
`ifdef NEURON_LEARN_BIAS_EN
    bias_d  = bias_q;
`endif
    case (state_q)
      S_INIT: begin
        w_d[idx_q*W_W +: W_W] = $signed(lfsr_q[W_W-1:0]) >>> 3;
        lfsr_d = lfsr_step(lfsr_q);
`ifdef NEURON_LEARN_BIAS_EN
        bias_d = '0;
`endif
        if (idx_q == FWD_LAST) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_IDLE: begin
        // Host write lands before an accept in the same cycle.
        if (wr_en_i) begin
          if (wr_idx_i < N_IDX) w_d[wr_idx_i*W_W +: W_W] = wr_data_i;
`ifdef NEURON_LEARN_BIAS_EN
          else if (wr_idx_i == N_IDX) bias_d = wr_data_i;
`endif
        end
        if (in_valid_i) begin
          in_d    = in_i;
          eo_d    = expected_out_i;
          learn_d = learn_i;
          amin_d  = act_min_i;
          amax_d  = act_max_i;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_FWD;
        end
      end
      S_FWD: begin
        acc_d = mac_n;
        if (idx_q == FWD_LAST) begin
          idx_d   = '0;
          state_d = S_ACT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_ACT: begin
        out_d = out_n;
        idx_d = '0;
        if (learn_q) begin
          state_d = S_UPD;
        end else begin
          ein_d   = in_q;
          state_d = S_DONE;
        end
      end
      S_UPD: begin
        // Both updates read the pre-update weight of the same element.
        if (idx_q < N_IDX) begin
          ein_d[ui*IN_W +: IN_W] = ein_n;
          w_d[ui*W_W +: W_W]     = w_n;
        end
`ifdef NEURON_LEARN_BIAS_EN
        else begin
          bias_d = bias_n;
        end
`endif
        if (idx_q == UPD_LAST) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!ov_q) begin
          ov_d = 1'b1;
        end else if (out_ready_i) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State, weights and visible results; reset reseeds and clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      lfsr_q  <= SEED;
      w_q     <= '0;
      acc_q   <= '0;
      ein_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
`ifdef NEURON_LEARN_BIAS_EN
      bias_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      ein_q   <= ein_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
`ifdef NEURON_LEARN_BIAS_EN
      bias_q  <= bias_d;
`endif
    end
  end

  // Accepted-transaction operands; only meaningful after an accept.
  always_ff @(posedge clk) begin
    in_q    <= in_d;
    eo_q    <= eo_d;
    learn_q <= learn_d;
    amin_q  <= amin_d;
    amax_q  <= amax_d;
  end

  assign in_ready_o    = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign out_valid_o   = ov_q;
  assign out_o         = out_q;
  assign expected_in_o = ein_q;
  assign weights_o     = w_q;
`ifdef NEURON_LEARN_BIAS_EN
  assign bias_o        = bias_q;
`endif

endmodule

// File: tb/tb_neuron_learn_seq.sv
// tb_neuron_learn_seq: directed bench for neuron_learn_seq (default build, no bias).
module tb_neuron_learn_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        learn = 1'b0;
  logic [31:0] vin = '0;
  logic [7:0]  exp_out = '0;
  logic signed [15:0] act_min = '0;
  logic signed [15:0] act_max = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_idx = '0;
  logic signed [15:0] wr_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  dout;
  logic [31:0] exp_in;
  logic [63:0] weights;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  out;
    logic [31:0] ein;
    logic [63:0] w;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   mw[4];
  int   tin[4];

  always #5 clk = ~clk;

  neuron_learn_seq #(
    .N(4), .IN_W(8), .W_W(16), .FRAC(12), .LR_SHIFT(2), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .learn_i(learn),
    .in_i(vin), .expected_out_i(exp_out),
    .act_min_i(act_min), .act_max_i(act_max),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_o(dout),
    .expected_in_o(exp_in), .weights_o(weights), .busy_o(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int satu(input longint v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  function automatic int sats(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic logic [63:0] packw();
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = mw[i][15:0];
    return r;
  endfunction

  task automatic lfsr_model();
    logic [15:0] s;
    logic signed [15:0] t;
    s = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      t = s;
      mw[i] = t >>> 3;
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
  endtask

  // Reference neuron: forward pass, clip, and optional delta-rule update on mw.
  task automatic model(input logic [7:0] eo, input logic lrn, input longint amin,
                       input longint amax, output exp_t e);
    longint acc, a, c, err;
    int o, ei;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += longint'(tin[i]) * longint'(mw[i]);
    a = acc >>> 8;
    if (amax < amin)   c = amin;
    else if (a < amin) c = amin;
    else if (a > amax) c = amax;
    else               c = a;
    o = satu((c - amin) >>> 4);
    e.out = o[7:0];
    if (lrn) begin
      err = longint'(eo) - longint'(o);
      for (int i = 0; i < 4; i++) begin
        ei = satu(longint'(tin[i]) + ((err * longint'(mw[i])) >>> 14));
        e.ein[i*8 +: 8] = ei[7:0];
        mw[i] = sats(longint'(mw[i]) + ((err * longint'(tin[i])) >>> 6));
      end
      e.lat = 10;
    end else begin
      for (int i = 0; i < 4; i++) e.ein[i*8 +: 8] = tin[i][7:0];
      e.lat = 6;
    end
    e.w = packw();
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!in_ready && k < 40) begin tick(); k++; end
    check(tag, in_ready, 1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick();
    tick();
    check({tag, "_rst_ready"}, in_ready, 0);
    check({tag, "_rst_valid"}, out_valid, 0);
    check({tag, "_rst_out"}, dout, 0);
    check({tag, "_rst_ein"}, exp_in, 0);
    check({tag, "_rst_w"}, weights, 0);
    check({tag, "_rst_busy"}, busy, 1);
    rst_n = 1'b1;
    repeat (3) tick();
    check({tag, "_ready_early"}, in_ready, 0);
    tick();
    check({tag, "_ready_at4"}, in_ready, 1);
    lfsr_model();
    check({tag, "_lfsr_w"}, weights, packw());
  endtask

  task automatic write_w(input logic [2:0] idx, input logic [15:0] data);
    wait_idle("wr_idle");
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    tick();
    wr_en = 1'b0;
    if (idx < 3'd4) mw[idx] = int'($signed(data));
  endtask

  task automatic run_txn(input string tag, input logic [31:0] v, input logic [7:0] eo,
                         input logic lrn, input logic signed [15:0] amin,
                         input logic signed [15:0] amax, input int hold,
                         input logic wsame, input logic [2:0] widx, input logic [15:0] wdat);
    exp_t e;
    int k;
    wait_idle({tag, "_idle"});
    for (int i = 0; i < 4; i++) tin[i] = int'(v[i*8 +: 8]);
    if (wsame && widx < 3'd4) mw[widx] = int'($signed(wdat));
    model(eo, lrn, longint'(amin), longint'(amax), e);
    sb.push_back(e);
    in_valid = 1'b1; vin = v; exp_out = eo; learn = lrn;
    act_min = amin; act_max = amax;
    wr_en = wsame; wr_idx = widx; wr_data = wdat;
    tick();
    in_valid = 1'b0; wr_en = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin tick(); k++; end
    e = sb.pop_front();
    check({tag, "_latency"}, k, e.lat);
    check({tag, "_out"}, dout, e.out);
    check({tag, "_ein"}, exp_in, e.ein);
    check({tag, "_w"}, weights, e.w);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; wr_en = 1'b1; wr_idx = 3'd0; wr_data = 16'h1234;
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_out"}, dout, e.out);
      check({tag, "_hold_ein"}, exp_in, e.ein);
      check({tag, "_hold_ready"}, in_ready, 0);
    end
    in_valid = 1'b0; wr_en = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_consumed"}, out_valid, 0);
    check({tag, "_ready_after"}, in_ready, 1);
    check({tag, "_w_after"}, weights, e.w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up and repeated reset must seed identical weights.
    do_reset("por");
    do_reset("rst2");

    // Bias index is out of range without the bias feature.
    write_w(3'd4, 16'h5555);
    tick();
    check("bias_idx_ignored", weights, packw());

    // Unity weights, forward only, then with learning.
    for (int i = 0; i < 4; i++) write_w(3'(i), 16'h1000);
    run_txn("fwd", 32'h20202020, 8'h00, 1'b0, 16'sh0000, 16'sh1000, 0, 1'b0, 3'd0, 16'h0);
    check("fwd_w_literal", weights, 64'h1000100010001000);
    run_txn("learn", 32'h20202020, 8'hC0, 1'b1, 16'sh0000, 16'sh1000, 0, 1'b0, 3'd0, 16'h0);
    check("learn_w_literal", weights, 64'h1020102010201020);
    check("learn_ein_literal", exp_in, 32'h30303030);

    // Back-pressure: result held, new requests and writes ignored.
    for (int i = 0; i < 4; i++) write_w(3'(i), 16'h1000);
    run_txn("hold", 32'h20202020, 8'h00, 1'b0, 16'sh0000, 16'sh1000, 5, 1'b0, 3'd0, 16'h0);
    tick();
    check("hold_no_new_txn", busy, 0);

    // Saturation of weights and upstream targets.
    for (int i = 0; i < 4; i++) write_w(3'(i), 16'h7FFF);
    run_txn("sat", 32'hFFFFFFFF, 8'hFF, 1'b1, 16'sh0000, 16'sh0800, 0, 1'b0, 3'd0, 16'h0);
    check("sat_out_literal", dout, 8'h80);
    check("sat_w_literal", weights, 64'h7FFF7FFF7FFF7FFF);

    // Inverted clip window forces c = act_min.
    run_txn("inv_clip", 32'h10203040, 8'h40, 1'b0, 16'sh0100, 16'sh0080, 0, 1'b0, 3'd0, 16'h0);

    // Mixed-sign weights, negative lower clip, write in the accept cycle.
    write_w(3'd0, 16'hF000);
    write_w(3'd1, 16'h2000);
    write_w(3'd3, 16'hC000);
    run_txn("mixed", 32'h5A3C7F10, 8'h10, 1'b1, -16'sh1000, 16'sh1000, 0, 1'b1, 3'd2, 16'hE800);
    run_txn("mixed2", 32'h01FE80C3, 8'hF0, 1'b1, -16'sh0800, 16'sh0400, 2, 1'b0, 3'd0, 16'h0);

    // Reset in the middle of the update phase.
    for (int i = 0; i < 4; i++) write_w(3'(i), 16'h1000);
    wait_idle("midrst_idle");
    in_valid = 1'b1; vin = 32'h20202020; exp_out = 8'hC0; learn = 1'b1;
    act_min = 16'sh0000; act_max = 16'sh1000;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("midrst_busy", busy, 1);
    check("midrst_pre_valid", out_valid, 0);
    do_reset("midrst");

    // Learning from LFSR weights after the reset.
    run_txn("post_rst", 32'h80402010, 8'h20, 1'b1, 16'sh0000, 16'sh1000, 0, 1'b0, 3'd0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
